alu_cmd_unit: RTL and testbench

Command-side front end for the 8-bit ALU. It is the synthesizable counterpart of the bench stimulus driver, for use on the Cyclone II board. Upstream logic pushes ALU commands (operands, carry-in, mode, control word) through a valid/ready handshake into a small FIFO. The unit drives each command onto the combinational ALU, holds the operands stable for a settle window, and captures `out`/`c_out`. It returns each result, in order and tagged, through a second valid/ready handshake.

---
 rtl/alu_cmd_unit.sv | 170 +++++++++++++++++
 tb/tb_alu_cmd_unit.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_unit.sv
// alu_cmd_unit: queues ALU commands, drives each one onto a combinational ALU,
// holds the operands for a settle window, and returns tagged results in order.
module alu_cmd_unit #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [7:0]              cmd_a,
    input  logic [7:0]              cmd_b,
    input  logic                    cmd_c_in,
    input  logic [2:0]              cmd_control_line,
    input  logic                    cmd_mode_select,
    output logic [7:0]              alu_a,
    output logic [7:0]              alu_b,
    output logic                    alu_c_in,
    output logic [2:0]              alu_control_line,
    output logic                    alu_mode_select,
    input  logic [7:0]              alu_out,
    input  logic                    alu_c_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [7:0]              rsp_out,
    output logic                    rsp_c_out,
    output logic [3:0]              rsp_tag,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TAG_W = 4;

    // One queued command; field order gives the {mode, control, c_in, b, a} layout.
    typedef struct packed {
        logic       mode;
        logic [2:0] control;
        logic       c_in;
        logic [7:0] b;
        logic [7:0] a;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    cmd_t              mem [DEPTH];
    cmd_t              wr_entry;
    cmd_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  settle_cnt;
    logic              push;
    logic              pop;
    logic              fifo_nempty;
    logic              settle_done;

    // Handshake and pop decisions; cmd_ready looks only at the registered level.
    assign cmd_ready   = (level != LVL_W'(DEPTH));
    assign push        = cmd_valid && cmd_ready;
    assign fifo_nempty = (level != '0);
    assign pop         = fifo_nempty &&
                         ((state == IDLE) || ((state == RESP) && rsp_valid && rsp_ready));
    assign settle_done = (settle_cnt == CNT_W'(SETTLE - 1));

    // Pack the incoming command and expose the FIFO head.
    always_comb begin
        wr_entry         = '0;
        wr_entry.mode    = cmd_mode_select;
        wr_entry.control = cmd_control_line;
        wr_entry.c_in    = cmd_c_in;
        wr_entry.b       = cmd_b;
        wr_entry.a       = cmd_a;
        head             = mem[rd_ptr];
    end

    // Command storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel in level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Sequencer: load a command, wait out the settle window, capture, hand back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_c_in         <= 1'b0;
            alu_control_line <= '0;
            alu_mode_select  <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_out          <= '0;
            rsp_c_out        <= 1'b0;
            rsp_tag          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a            <= head.a;
                        alu_b            <= head.b;
                        alu_c_in         <= head.c_in;
                        alu_control_line <= head.control;
                        alu_mode_select  <= head.mode;
                        settle_cnt       <= '0;
                        state            <= DRIVE;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_done) begin
                        rsp_out   <= alu_out;
                        rsp_c_out <= alu_c_out;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_tag   <= rsp_tag + TAG_W'(1);
                        if (pop) begin
                            alu_a            <= head.a;
                            alu_b            <= head.b;
                            alu_c_in         <= head.c_in;
                            alu_control_line <= head.control;
                            alu_mode_select  <= head.mode;
                            settle_cnt       <= '0;
                            state            <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_unit.sv
// Bench for alu_cmd_unit: two instances (SETTLE=1 and SETTLE=4) behind adder stubs,
// directed commands with a queue of expected results checked by per-unit monitors.
module tb_alu_cmd_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [3:0] tag;
        logic [7:0] out;
        logic       c_out;
    } exp_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Unit 1 (SETTLE = 1)
    logic             rst1;
    logic             u1_cmd_valid;
    logic             u1_cmd_ready;
    logic [7:0]       u1_cmd_a;
    logic [7:0]       u1_cmd_b;
    logic             u1_cmd_c_in;
    logic [2:0]       u1_cmd_control_line;
    logic             u1_cmd_mode_select;
    logic [7:0]       u1_alu_a;
    logic [7:0]       u1_alu_b;
    logic             u1_alu_c_in;
    logic [2:0]       u1_alu_control_line;
    logic             u1_alu_mode_select;
    logic [7:0]       u1_alu_out;
    logic             u1_alu_c_out;
    logic             u1_rsp_valid;
    logic             u1_rsp_ready;
    logic [7:0]       u1_rsp_out;
    logic             u1_rsp_c_out;
    logic [3:0]       u1_rsp_tag;
    logic [LVL_W-1:0] u1_level;
    logic             u1_rdy_man;
    logic             rand_en;
    logic             rdy_rand;

    // Unit 4 (SETTLE = 4)
    logic             rst4;
    logic             u4_cmd_valid;
    logic             u4_cmd_ready;
    logic [7:0]       u4_cmd_a;
    logic [7:0]       u4_cmd_b;
    logic             u4_cmd_c_in;
    logic [2:0]       u4_cmd_control_line;
    logic             u4_cmd_mode_select;
    logic [7:0]       u4_alu_a;
    logic [7:0]       u4_alu_b;
    logic             u4_alu_c_in;
    logic [2:0]       u4_alu_control_line;
    logic             u4_alu_mode_select;
    logic [7:0]       u4_alu_out;
    logic             u4_alu_c_out;
    logic             u4_rsp_valid;
    logic             u4_rsp_ready;
    logic [7:0]       u4_rsp_out;
    logic             u4_rsp_c_out;
    logic [3:0]       u4_rsp_tag;
    logic [LVL_W-1:0] u4_level;

    exp_t       q1[$];
    exp_t       q4[$];
    logic [3:0] tag1 = 4'd0;
    logic [3:0] tag4 = 4'd0;
    int         rises4 = 0;

    assign u1_rsp_ready = rand_en ? rdy_rand : u1_rdy_man;

    // Adder stubs standing in for the ALU
    assign {u1_alu_c_out, u1_alu_out} = 9'(u1_alu_a) + 9'(u1_alu_b) + 9'(u1_alu_c_in);
    assign {u4_alu_c_out, u4_alu_out} = 9'(u4_alu_a) + 9'(u4_alu_b) + 9'(u4_alu_c_in);

    alu_cmd_unit #(.DEPTH(DEPTH), .SETTLE(1)) u_dut1 (
        .clk              (clk),
        .rst              (rst1),
        .cmd_valid        (u1_cmd_valid),
        .cmd_ready        (u1_cmd_ready),
        .cmd_a            (u1_cmd_a),
        .cmd_b            (u1_cmd_b),
        .cmd_c_in         (u1_cmd_c_in),
        .cmd_control_line (u1_cmd_control_line),
        .cmd_mode_select  (u1_cmd_mode_select),
        .alu_a            (u1_alu_a),
        .alu_b            (u1_alu_b),
        .alu_c_in         (u1_alu_c_in),
        .alu_control_line (u1_alu_control_line),
        .alu_mode_select  (u1_alu_mode_select),
        .alu_out          (u1_alu_out),
        .alu_c_out        (u1_alu_c_out),
        .rsp_valid        (u1_rsp_valid),
        .rsp_ready        (u1_rsp_ready),
        .rsp_out          (u1_rsp_out),
        .rsp_c_out        (u1_rsp_c_out),
        .rsp_tag          (u1_rsp_tag),
        .level            (u1_level)
    );

    alu_cmd_unit #(.DEPTH(DEPTH), .SETTLE(4)) u_dut4 (
        .clk              (clk),
        .rst              (rst4),
        .cmd_valid        (u4_cmd_valid),
        .cmd_ready        (u4_cmd_ready),
        .cmd_a            (u4_cmd_a),
        .cmd_b            (u4_cmd_b),
        .cmd_c_in         (u4_cmd_c_in),
        .cmd_control_line (u4_cmd_control_line),
        .cmd_mode_select  (u4_cmd_mode_select),
        .alu_a            (u4_alu_a),
        .alu_b            (u4_alu_b),
        .alu_c_in         (u4_alu_c_in),
        .alu_control_line (u4_alu_control_line),
        .alu_mode_select  (u4_alu_mode_select),
        .alu_out          (u4_alu_out),
        .alu_c_out        (u4_alu_c_out),
        .rsp_valid        (u4_rsp_valid),
        .rsp_ready        (u4_rsp_ready),
        .rsp_out          (u4_rsp_out),
        .rsp_c_out        (u4_rsp_c_out),
        .rsp_tag          (u4_rsp_tag),
        .level            (u4_level)
    );

    initial forever #5 clk = ~clk;

    // Cycle counter used for pulse spacing
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Random consumer back-pressure for unit 1
    initial begin
        rdy_rand = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Unit 1 monitor: compare every accepted response against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst1 && u1_rsp_valid && u1_rsp_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL u1_extra_rsp: got rsp_out=0x%0h tag=%0d, required no pending result", u1_rsp_out, u1_rsp_tag);
                end else begin
                    e = q1.pop_front();
                    chk("u1_rsp_out", 32'(u1_rsp_out), 32'(e.out));
                    chk("u1_rsp_c_out", 32'(u1_rsp_c_out), 32'(e.c_out));
                    chk("u1_rsp_tag", 32'(u1_rsp_tag), 32'(e.tag));
                end
            end
        end
    end

    // Unit 4 monitor: results, pulse spacing and operand stability before capture
    initial begin
        exp_t        e;
        logic [13:0] cur;
        logic [13:0] prev = '0;
        int          stable = 0;
        int          last_rise = -1;
        logic        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            cur = {u4_alu_a, u4_alu_b, u4_alu_c_in, u4_alu_control_line, u4_alu_mode_select};
            if (!rst4 && u4_rsp_valid && !prev_valid) begin
                rises4++;
                checks++;
                if (stable < 4) begin
                    errors++;
                    $display("FAIL u4_alu_stable: alu inputs held %0d cycles before capture, required at least 4", stable);
                end
                if (last_rise >= 0) begin
                    chk("u4_rsp_period", 32'(cyc - last_rise), 32'd5);
                end
                last_rise = cyc;
            end
            if (cur == prev) stable++;
            else stable = 1;
            prev = cur;
            prev_valid = u4_rsp_valid;
            if (!rst4 && u4_rsp_valid && u4_rsp_ready) begin
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL u4_extra_rsp: got rsp_out=0x%0h tag=%0d, required no pending result", u4_rsp_out, u4_rsp_tag);
                end else begin
                    e = q4.pop_front();
                    chk("u4_rsp_out", 32'(u4_rsp_out), 32'(e.out));
                    chk("u4_rsp_c_out", 32'(u4_rsp_c_out), 32'(e.c_out));
                    chk("u4_rsp_tag", 32'(u4_rsp_tag), 32'(e.tag));
                end
            end
        end
    end

    task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [2:0] ctl, input logic mode,
                         input logic [7:0] eo, input logic ec);
        int n;
        n = 0;
        u1_cmd_a = a;
        u1_cmd_b = b;
        u1_cmd_c_in = cin;
        u1_cmd_control_line = ctl;
        u1_cmd_mode_select = mode;
        u1_cmd_valid = 1'b1;
        while (!u1_cmd_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!u1_cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL u1_cmd_accept: cmd_ready=0 for %0d cycles, required 1", n);
            u1_cmd_valid = 1'b0;
            return;
        end
        q1.push_back('{tag: tag1, out: eo, c_out: ec});
        tag1 = tag1 + 4'd1;
        @(posedge clk);
        #1;
        u1_cmd_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [2:0] ctl, input logic mode,
                         input logic [7:0] eo, input logic ec);
        int n;
        n = 0;
        u4_cmd_a = a;
        u4_cmd_b = b;
        u4_cmd_c_in = cin;
        u4_cmd_control_line = ctl;
        u4_cmd_mode_select = mode;
        u4_cmd_valid = 1'b1;
        while (!u4_cmd_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!u4_cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL u4_cmd_accept: cmd_ready=0 for %0d cycles, required 1", n);
            u4_cmd_valid = 1'b0;
            return;
        end
        q4.push_back('{tag: tag4, out: eo, c_out: ec});
        tag4 = tag4 + 4'd1;
        @(posedge clk);
        #1;
        u4_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle1(input string name);
        int n;
        n = 0;
        while ((q1.size() != 0 || u1_rsp_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: unit 1 busy after %0d cycles, pending=%0d, required 0", name, n, q1.size());
        end
    endtask

    task automatic wait_idle4(input string name);
        int n;
        n = 0;
        while ((q4.size() != 0 || u4_rsp_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: unit 4 busy after %0d cycles, pending=%0d, required 0", name, n, q4.size());
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] sum;

        rst1 = 1'b1;
        rst4 = 1'b1;
        rand_en = 1'b0;
        u1_rdy_man = 1'b1;
        u1_cmd_valid = 1'b0;
        u1_cmd_a = '0;
        u1_cmd_b = '0;
        u1_cmd_c_in = 1'b0;
        u1_cmd_control_line = '0;
        u1_cmd_mode_select = 1'b0;
        u4_rsp_ready = 1'b1;
        u4_cmd_valid = 1'b0;
        u4_cmd_a = '0;
        u4_cmd_b = '0;
        u4_cmd_c_in = 1'b0;
        u4_cmd_control_line = '0;
        u4_cmd_mode_select = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0;
        rst4 = 1'b0;

        // Reset values
        chk("rst_cmd_ready", 32'(u1_cmd_ready), 32'd1);
        chk("rst_level", 32'(u1_level), 32'd0);
        chk("rst_alu_a", 32'(u1_alu_a), 32'd0);
        chk("rst_alu_b", 32'(u1_alu_b), 32'd0);
        chk("rst_alu_ctl", 32'({u1_alu_c_in, u1_alu_control_line, u1_alu_mode_select}), 32'd0);
        chk("rst_rsp_valid", 32'(u1_rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'({u1_rsp_c_out, u1_rsp_out}), 32'd0);
        chk("rst_rsp_tag", 32'(u1_rsp_tag), 32'd0);
        chk("rst4_level", 32'(u4_level), 32'd0);
        chk("rst4_cmd_ready", 32'(u4_cmd_ready), 32'd1);

        // Single command 2+3: pop one edge after acceptance, result one edge later
        send1(8'd2, 8'd3, 1'b0, 3'd0, 1'b1, 8'd5, 1'b0);
        chk("single_level_after_push", 32'(u1_level), 32'd1);
        chk("single_valid_e0", 32'(u1_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("single_valid_e1", 32'(u1_rsp_valid), 32'd0);
        chk("single_alu_a", 32'(u1_alu_a), 32'd2);
        chk("single_alu_b", 32'(u1_alu_b), 32'd3);
        chk("single_alu_mode", 32'(u1_alu_mode_select), 32'd1);
        chk("single_level_after_pop", 32'(u1_level), 32'd0);
        @(posedge clk);
        #1;
        chk("single_valid_e2", 32'(u1_rsp_valid), 32'd1);
        chk("single_rsp_out", 32'(u1_rsp_out), 32'd5);
        chk("single_rsp_tag", 32'(u1_rsp_tag), 32'd0);

        // Overflow FF+01+1 = 0x101
        send1(8'hFF, 8'h01, 1'b1, 3'd2, 1'b0, 8'h01, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_valid", 32'(u1_rsp_valid), 32'd1);
        chk("ovf_rsp_out", 32'(u1_rsp_out), 32'h01);
        chk("ovf_rsp_c_out", 32'(u1_rsp_c_out), 32'd1);
        wait_idle1("ovf_drain");

        // Fill with consumer stalled: 5 accepted, command 0 parked in RESP, 4 queued
        u1_rdy_man = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send1(8'(8'h10 + i), 8'(i), 1'b0, 3'(i), 1'b0, 8'(8'h10 + 2 * i), 1'b0);
        end
        chk("fill_level", 32'(u1_level), 32'd4);
        chk("fill_cmd_ready", 32'(u1_cmd_ready), 32'd0);
        chk("fill_rsp_valid", 32'(u1_rsp_valid), 32'd1);
        u1_cmd_a = 8'hEE;
        u1_cmd_b = 8'hEE;
        u1_cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        u1_cmd_valid = 1'b0;
        chk("full_level_held", 32'(u1_level), 32'd4);
        chk("stall_alu_a", 32'(u1_alu_a), 32'h10);
        chk("stall_alu_b", 32'(u1_alu_b), 32'h00);
        chk("stall_rsp_out", 32'(u1_rsp_out), 32'h10);
        chk("stall_rsp_tag", 32'(u1_rsp_tag), 32'd2);

        // Release one result: command 1 enters DRIVE with 3 left, then reset mid-flight
        u1_rdy_man = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_level", 32'(u1_level), 32'd3);
        chk("pre_rst_valid", 32'(u1_rsp_valid), 32'd0);
        chk("pre_rst_alu_a", 32'(u1_alu_a), 32'h11);
        rst1 = 1'b1;
        q1.delete();
        tag1 = 4'd0;
        #1;
        chk("mid_rst_level", 32'(u1_level), 32'd0);
        chk("mid_rst_valid", 32'(u1_rsp_valid), 32'd0);
        chk("mid_rst_alu", 32'({u1_alu_a, u1_alu_b}), 32'd0);
        chk("mid_rst_tag", 32'(u1_rsp_tag), 32'd0);
        chk("mid_rst_cmd_ready", 32'(u1_cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        rst1 = 1'b0;

        // Sweep mode x control with random back-pressure; tags 0..15 then wrap to 0
        rand_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 8'(i * 17);
            b = 8'(8'hA0 + i);
            cin = 1'(i % 2);
            sum = 9'(a) + 9'(b) + 9'(cin);
            send1(a, b, cin, 3'(i % 8), 1'(i / 8), sum[7:0], sum[8]);
        end
        send1(8'h80, 8'h80, 1'b0, 3'd7, 1'b1, 8'h00, 1'b1);
        wait_idle1("sweep_drain");
        rand_en = 1'b0;
        u1_rdy_man = 1'b1;
        chk("sweep_tag_wrapped", 32'(u1_rsp_tag), 32'd1);

        // SETTLE = 4: three queued commands, one result every 5 cycles
        for (int i = 0; i < 3; i++) begin
            send4(8'(i + 1), 8'h40, 1'b1, 3'(i), 1'b0, 8'(8'h42 + i), 1'b0);
        end
        wait_idle4("settle4_drain");
        chk("settle4_results", 32'(rises4), 32'd3);
        chk("u1_queue_empty", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
